cc_ctrl_fsm: RTL and testbench

- Read-only, direct-mapped cache controller FSM: 32-bit address, tag[31:15], index[14:6], offset[5:0]; 64-byte lines, 512 sets.
- Accepts one core request at a time and sequences the tag SRAM/data SRAM lookup and the tag comparator.
- On hit it returns the selected 32-bit word. On miss it issues an 8-beat 64-bit memory burst, fills the line, writes the tag, then responds.
- Sits between the core request port and the comparator, the SRAMs and the memory read port.

---
 rtl/cc_pkg.sv | 31 +++
 rtl/cc_fill_ctr.sv | 30 +++
 rtl/cc_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_cc_ctrl_fsm.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types, geometry constants and helpers for the cache controller
package cc_pkg;

    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 17;
    localparam int IDX_W      = 9;
    localparam int OFF_W      = 6;
    localparam int WORD_W     = 32;
    localparam int BEAT_W     = 64;
    localparam int LINE_W     = 512;
    localparam int FILL_BEATS = 8;
    localparam int BEAT_CNT_W = 3;
    localparam int WSEL_W     = 4;

    localparam logic [3:0] MEM_ARLEN = 4'(FILL_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        FILL,
        TAG_WR,
        RESP
    } cc_state_e;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [WSEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cc_fill_ctr.sv
// rtl/cc_fill_ctr.sv - line-fill beat counter with critical-word capture
module cc_fill_ctr
    import cc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_en,
    input  logic [OFF_W-1:0]      offset,
    input  logic [BEAT_W-1:0]     beat_data,
    output logic [BEAT_CNT_W-1:0] beat,
    output logic                  done,
    output logic [WORD_W-1:0]     crit_word
);

    assign done = beat_en && (beat == BEAT_CNT_W'(FILL_BEATS - 1));

    // The counter rolls over to 0 on the last beat, so every fill starts at slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat      <= '0;
            crit_word <= '0;
        end else if (beat_en) begin
            beat <= beat + 1'b1;
            if (beat == offset[OFF_W-1:3]) begin
                crit_word <= offset[2] ? beat_data[BEAT_W-1:WORD_W] : beat_data[WORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cc_ctrl_fsm.sv
// rtl/cc_ctrl_fsm.sv - read-only direct-mapped cache controller FSM; CC_PERF_CNT_EN adds hit/miss counters
module cc_ctrl_fsm
    import cc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inct_arvalid_i,
    input  logic [ADDR_W-1:0]     inct_araddr_i,
    output logic                  inct_arready_o,
    output logic                  inct_rvalid_o,
    output logic [WORD_W-1:0]     inct_rdata_o,
    input  logic                  inct_rready_i,
    output logic                  hs_pulse_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [IDX_W-1:0]      index_o,
    output logic [OFF_W-1:0]      offset_o,
    input  logic                  hit_i,
    input  logic                  miss_i,
    input  logic [LINE_W-1:0]     data_rdata_i,
    output logic                  tag_wren_o,
    output logic [TAG_W:0]        tag_wdata_o,
    output logic                  data_wren_o,
    output logic [BEAT_CNT_W-1:0] data_wbeat_o,
    output logic [BEAT_W-1:0]     data_wdata_o,
    output logic [IDX_W-1:0]      wr_index_o,
    output logic                  mem_arvalid_o,
    output logic [ADDR_W-1:0]     mem_araddr_o,
    output logic [3:0]            mem_arlen_o,
    input  logic                  mem_arready_i,
    input  logic                  mem_rvalid_i,
    input  logic [BEAT_W-1:0]     mem_rdata_i,
    input  logic                  mem_rlast_i,
    output logic                  mem_rready_o
`ifdef CC_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    cc_state_e state, state_n;

    logic [ADDR_W-1:0]     addr_q;
    logic                  accept;
    logic                  lookup_eval;
    logic                  beat_en;
    logic                  fill_done;
    logic [BEAT_CNT_W-1:0] beat;
    logic [WORD_W-1:0]     crit_word;

    assign accept      = (state == IDLE) && inct_arvalid_i && inct_arready_o;
    // The first LOOKUP cycle issues the SRAM read; the comparator answers in the second.
    assign lookup_eval = (state == LOOKUP) && !hs_pulse_o;
    assign beat_en     = (state == FILL) && mem_rvalid_i && mem_rready_o;

    assign tag_o        = addr_q[ADDR_W-1 -: TAG_W];
    assign index_o      = addr_q[OFF_W +: IDX_W];
    assign offset_o     = addr_q[OFF_W-1:0];
    assign wr_index_o   = addr_q[OFF_W +: IDX_W];
    assign mem_araddr_o = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_arlen_o  = MEM_ARLEN;

    assign data_wren_o  = beat_en;
    assign data_wbeat_o = beat;
    assign data_wdata_o = beat_en ? mem_rdata_i : '0;

    cc_fill_ctr u_fill_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_en   (beat_en),
        .offset    (addr_q[OFF_W-1:0]),
        .beat_data (mem_rdata_i),
        .beat      (beat),
        .done      (fill_done),
        .crit_word (crit_word)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = LOOKUP;
            LOOKUP: begin
                if (lookup_eval) begin
                    if (hit_i)       state_n = RESP;
                    else if (miss_i) state_n = MISS_AR;
                end
            end
            MISS_AR: if (mem_arvalid_o && mem_arready_i) state_n = FILL;
            FILL:    if (fill_done) state_n = TAG_WR;
            TAG_WR:  state_n = RESP;
            RESP:    if (inct_rvalid_o && inct_rready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            inct_arready_o <= 1'b0;
            inct_rvalid_o  <= 1'b0;
            inct_rdata_o   <= '0;
            hs_pulse_o     <= 1'b0;
            tag_wren_o     <= 1'b0;
            tag_wdata_o    <= '0;
            mem_arvalid_o  <= 1'b0;
            mem_rready_o   <= 1'b0;
        end else begin
            state          <= state_n;
            inct_arready_o <= (state_n == IDLE);
            inct_rvalid_o  <= (state_n == RESP);
            hs_pulse_o     <= accept;
            tag_wren_o     <= (state_n == TAG_WR);
            tag_wdata_o    <= (state_n == TAG_WR) ? {1'b1, addr_q[ADDR_W-1 -: TAG_W]} : '0;
            mem_arvalid_o  <= (state_n == MISS_AR);
            mem_rready_o   <= (state_n == FILL);
            if (accept) begin
                addr_q <= inct_araddr_i;
            end
            if (lookup_eval && hit_i) begin
                inct_rdata_o <= line_word(data_rdata_i, addr_q[OFF_W-1:2]);
            end else if (state == TAG_WR) begin
                inct_rdata_o <= crit_word;
            end
        end
    end

`ifdef CC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (lookup_eval) begin
            if (hit_i) begin
                if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            end else if (miss_i) begin
                if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_lookup_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        lookup_eval |-> (hit_i ^ miss_i));
    a_rlast_on_last_beat: assert property (@(posedge clk) disable iff (!rst_n)
        beat_en |-> (mem_rlast_i == (beat == BEAT_CNT_W'(FILL_BEATS - 1))));
`endif

endmodule

// File: tb/tb_cc_ctrl_fsm.sv
// tb/tb_cc_ctrl_fsm.sv - self-checking bench for cc_ctrl_fsm
module tb_cc_ctrl_fsm;
    import cc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inct_arvalid_i;
    logic [31:0]  inct_araddr_i;
    logic         inct_arready_o;
    logic         inct_rvalid_o;
    logic [31:0]  inct_rdata_o;
    logic         inct_rready_i;
    logic         hs_pulse_o;
    logic [16:0]  tag_o;
    logic [8:0]   index_o;
    logic [5:0]   offset_o;
    logic         hit_i;
    logic         miss_i;
    logic [511:0] data_rdata_i;
    logic         tag_wren_o;
    logic [17:0]  tag_wdata_o;
    logic         data_wren_o;
    logic [2:0]   data_wbeat_o;
    logic [63:0]  data_wdata_o;
    logic [8:0]   wr_index_o;
    logic         mem_arvalid_o;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic         mem_arready_i;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;
    logic         mem_rlast_i;
    logic         mem_rready_o;
`ifdef CC_PERF_CNT_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    always #5 clk = ~clk;

    cc_ctrl_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inct_arvalid_i (inct_arvalid_i),
        .inct_araddr_i  (inct_araddr_i),
        .inct_arready_o (inct_arready_o),
        .inct_rvalid_o  (inct_rvalid_o),
        .inct_rdata_o   (inct_rdata_o),
        .inct_rready_i  (inct_rready_i),
        .hs_pulse_o     (hs_pulse_o),
        .tag_o          (tag_o),
        .index_o        (index_o),
        .offset_o       (offset_o),
        .hit_i          (hit_i),
        .miss_i         (miss_i),
        .data_rdata_i   (data_rdata_i),
        .tag_wren_o     (tag_wren_o),
        .tag_wdata_o    (tag_wdata_o),
        .data_wren_o    (data_wren_o),
        .data_wbeat_o   (data_wbeat_o),
        .data_wdata_o   (data_wdata_o),
        .wr_index_o     (wr_index_o),
        .mem_arvalid_o  (mem_arvalid_o),
        .mem_araddr_o   (mem_araddr_o),
        .mem_arlen_o    (mem_arlen_o),
        .mem_arready_i  (mem_arready_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_rlast_i    (mem_rlast_i),
        .mem_rready_o   (mem_rready_o)
`ifdef CC_PERF_CNT_EN
        ,
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [15:0] seed;
        int          ar_delay;
        bit          gaps;
        int          rr_delay;
        logic [31:0] exp_rdata;
        logic [31:0] exp_line;
        logic [17:0] exp_tag_wdata;
        logic [8:0]  exp_index;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          n_hits   = 0;
    int          n_misses = 0;

    always @(posedge clk) cycle++;

    // Memory word k of a line; beat b carries words 2b (low) and 2b+1 (high).
    function automatic logic [31:0] mdl_word(input logic [15:0] seed, input int k);
        return {seed, 16'(k) ^ 16'hA5A5};
    endfunction

    function automatic logic [63:0] mdl_beat(input logic [15:0] seed, input int b);
        return {mdl_word(seed, 2*b + 1), mdl_word(seed, 2*b)};
    endfunction

    function automatic logic [511:0] mdl_line(input logic [15:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = mdl_word(seed, k);
        return l;
    endfunction

    function automatic vec_t make_vec(input logic [31:0] addr, input bit hit, input logic [15:0] seed,
                                      input int ar_delay, input bit gaps, input int rr_delay);
        vec_t v;
        v.addr          = addr;
        v.hit           = hit;
        v.seed          = seed;
        v.ar_delay      = ar_delay;
        v.gaps          = gaps;
        v.rr_delay      = rr_delay;
        v.exp_rdata     = mdl_word(seed, int'(addr[5:2]));
        v.exp_line      = {addr[31:6], 6'b0};
        v.exp_tag_wdata = {1'b1, addr[31:15]};
        v.exp_index     = addr[14:6];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inct_arvalid_i = 0; inct_araddr_i = '0; inct_rready_i = 0;
        hit_i = 0; miss_i = 0; data_rdata_i = '0;
        mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_rlast_i = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_arready"}, inct_arready_o, 0);
        chk({tag, "_rvalid_rdata"}, {inct_rvalid_o, inct_rdata_o}, 0);
        chk({tag, "_hs_tagwr"}, {hs_pulse_o, tag_wren_o, tag_wdata_o}, 0);
        chk({tag, "_data_wr"}, {data_wren_o, data_wbeat_o}, 0);
        chk({tag, "_data_wdata"}, data_wdata_o, 0);
        chk({tag, "_mem"}, {mem_arvalid_o, mem_rready_o, mem_araddr_o}, 0);
    endtask

    // Responses are compared in order as the core-side handshake happens.
    always @(negedge clk) begin
        if (rst_n && inct_rvalid_o && inct_rready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: response 0x%0h with no expected entry", inct_rdata_o);
            end else begin
                chk("rdata", {32'b0, inct_rdata_o}, {32'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [31:0] addr);
        int n = 0;
        step();
        while (!inct_arready_o && n < 20) begin step(); n++; end
        chk("arready_idle", inct_arready_o, 1);
        inct_arvalid_i = 1;
        inct_araddr_i  = addr;
    endtask

    task automatic run_req(input vec_t v);
        int   acc_edge, ar_wait, rr_wait, beats, n;
        bit   ar_seen, tag_seen, rv_seen, done, hs_last;
        logic [31:0] rd_first;
        ar_wait = 0; rr_wait = 0; beats = 0;
        ar_seen = 0; tag_seen = 0; rv_seen = 0; done = 0;
        rd_first = '0;
        issue(v.addr);
        sb_q.push_back(v.exp_rdata);
        if (v.hit) n_hits++; else n_misses++;
        acc_edge = cycle + 1;
        step();
        inct_arvalid_i = 0;
        inct_araddr_i  = $urandom();
        chk("hs_pulse", hs_pulse_o, 1);
        chk("index", index_o, v.exp_index);
        chk("tag", tag_o, v.addr[31:15]);
        chk("offset", offset_o, v.addr[5:0]);
        hs_last = 1;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
            hit_i = 0; miss_i = 0; data_rdata_i = '0;
            if (hs_last) begin
                hit_i  = v.hit;
                miss_i = !v.hit;
                if (v.hit) data_rdata_i = mdl_line(v.seed);
            end
            hs_last = hs_pulse_o;
            mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_rlast_i = 0;
            inct_rready_i = 0;
            if (mem_arvalid_o) begin
                ar_seen = 1;
                chk("mem_araddr_stable", mem_araddr_o, v.exp_line);
                mem_arready_i = (ar_wait >= v.ar_delay);
                if (mem_arready_i) chk("mem_arlen", mem_arlen_o, 7);
                ar_wait++;
            end
            if (mem_rready_o && beats < 8 && !(v.gaps && $urandom_range(0, 2) == 0)) begin
                mem_rvalid_i = 1;
                mem_rdata_i  = mdl_beat(v.seed, beats);
                mem_rlast_i  = (beats == 7);
            end
            if (tag_wren_o) begin
                tag_seen = 1;
                chk("tag_wdata", tag_wdata_o, v.exp_tag_wdata);
                chk("tag_wr_index", wr_index_o, v.exp_index);
                chk("tag_after_fill", beats, 8);
            end
            if (inct_rvalid_o) begin
                if (!rv_seen) begin
                    rv_seen  = 1;
                    rd_first = inct_rdata_o;
                    if (v.hit) chk("hit_turnaround", cycle + 1 - acc_edge, 3);
                end else begin
                    chk("rdata_stable", inct_rdata_o, rd_first);
                    chk("rvalid_held", inct_rvalid_o, 1);
                end
                chk("arready_in_resp", inct_arready_o, 0);
                inct_rready_i = (rr_wait >= v.rr_delay);
                rr_wait++;
                if (inct_rready_i) done = 1;
            end
            #1;
            chk("data_wren", data_wren_o, mem_rvalid_i);
            if (mem_rvalid_i) begin
                chk("data_wbeat", data_wbeat_o, beats);
                chk("data_wdata", data_wdata_o, mdl_beat(v.seed, beats));
                chk("data_wr_index", wr_index_o, v.exp_index);
                beats++;
            end
        end
        chk("req_done", done, 1);
        chk("ar_issued", ar_seen, !v.hit);
        chk("tag_written", tag_seen, !v.hit);
        chk("beats_written", beats, v.hit ? 0 : 8);
        step();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        vecs[0] = make_vec(32'h0001_2344, 0, 16'h1111, 0, 0, 0);
        vecs[1] = make_vec(32'h0001_2344, 1, 16'h1111, 0, 0, 0);
        vecs[2] = make_vec(32'h0000_0000, 1, 16'h2222, 0, 0, 5);
        vecs[3] = make_vec(32'hABCD_E03C, 0, 16'h3333, 4, 1, 0);
        vecs[4] = make_vec(32'hFFFF_FFC0, 0, 16'h4444, 1, 0, 2);
        vecs[5] = make_vec(32'h8000_003C, 1, 16'h5555, 0, 0, 0);
        vecs[6] = make_vec(32'h0000_7FF8, 0, 16'h6666, 0, 1, 1);
        vecs[7] = make_vec(32'h1234_5660, 1, 16'h7777, 0, 0, 3);

        rst_n = 0;
        idle_inputs();
        mem_rvalid_i = 1;
        mem_rdata_i  = 64'hDEAD_BEEF_0123_4567;
        repeat (3) step();
        chk_outputs_zero("reset");
        idle_inputs();
        rst_n = 1;
        step();
        chk("arready_after_reset", inct_arready_o, 1);

        for (int i = 0; i < 8; i++) run_req(vecs[i]);

        // Abort a fill after beat 3 with a reset.
        v = make_vec(32'h0004_5678, 0, 16'h8888, 0, 0, 0);
        issue(v.addr);
        step();
        inct_arvalid_i = 0;
        step();
        miss_i = 1;
        step();
        miss_i = 0;
        chk("abort_arvalid", mem_arvalid_o, 1);
        mem_arready_i = 1;
        step();
        mem_arready_i = 0;
        n = 0;
        for (int b = 0; b < 4 && n < 20; n++) begin
            if (mem_rready_o) begin
                mem_rvalid_i = 1;
                mem_rdata_i  = mdl_beat(v.seed, b);
                b++;
            end
            step();
            mem_rvalid_i = 0;
        end
        chk("abort_beat_cnt", data_wbeat_o, 4);
        rst_n = 0;
        step();
        n_hits = 0;
        n_misses = 0;
        chk_outputs_zero("abort");
        rst_n = 1;
        step();
        chk("abort_arready", inct_arready_o, 1);
        chk("abort_no_tag_wr", tag_wren_o, 0);

        run_req(vecs[0]);
        run_req(vecs[1]);
        run_req(vecs[5]);
`ifdef CC_PERF_CNT_EN
        chk("perf_miss_cnt", miss_cnt_o, n_misses);
        chk("perf_hit_cnt", hit_cnt_o, n_hits);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
